perf_ctrl: RTL and testbench

Synthesizable run/halt controller and counter bank for the core's performance monitoring. Sequences a measurement window from a start pulse to halt, stop or watchdog timeout, and counts cycles, retired instructions (W_v) and per-event stall inputs. Exposes every counter and a status word through a req/ack read port. It sits beside the writeback stage and is the hardware replacement for the simulation-only cycle/instruction counter.

---
 rtl/perf_pkg.sv | 24 ++
 rtl/perf_ctrl_if.sv | 16 +
 rtl/sat_counter.sv | 35 +++
 rtl/perf_ctrl.sv | 155 +++++++++++++++
 tb/tb_perf_ctrl.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/perf_pkg.sv
// perf_pkg: shared definitions for the performance-monitor controller.
//   state_e      - window sequencer states (IDLE, RUN, DRAIN, DONE)
//   SEL_*        - rd_sel codes for the counter read port
//   STB_*        - bit positions inside the status word
package perf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [2:0] SEL_CYCLE  = 3'd0;
    localparam logic [2:0] SEL_INSTR  = 3'd1;
    localparam logic [2:0] SEL_EV0    = 3'd2;
    localparam logic [2:0] SEL_STATUS = 3'd7;

    localparam int unsigned STB_STATE   = 0;  // bits [1:0]
    localparam int unsigned STB_RUNNING = 2;
    localparam int unsigned STB_DONE    = 3;
    localparam int unsigned STB_TIMEOUT = 4;

endpackage

// File: rtl/perf_ctrl_if.sv
// perf_ctrl_if: req/ack counter read port.
//   rd_req  - read request, held by the master until rd_ack
//   rd_sel  - counter select
//   rd_ack  - one-cycle acknowledge from the slave
//   rd_data - read data, valid while rd_ack is high
interface perf_ctrl_if #(
    parameter int unsigned CNT_W = 32
) ();
    logic             rd_req;
    logic [2:0]       rd_sel;
    logic             rd_ack;
    logic [CNT_W-1:0] rd_data;

    modport master (output rd_req, output rd_sel, input rd_ack, input rd_data);
    modport slave  (input rd_req, input rd_sel, output rd_ack, output rd_data);
endinterface

// File: rtl/sat_counter.sv
// sat_counter: CNT_W-bit up counter that sticks at all-ones.
//   clk, rst - clock, synchronous active-high reset
//   clr      - synchronous clear (wins over inc)
//   inc      - increment request
//   q        - current count
module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);
    logic [CNT_W-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && (q_q != '1)) begin
            q_d = q_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;
endmodule

// File: rtl/perf_ctrl.sv
// perf_ctrl: measurement-window sequencer and counter bank.
//   clk, rst          - clock, synchronous active-high reset
//   start             - pulse: open a window from IDLE or DONE
//   stop, isHalt      - close the window (enter DRAIN)
//   W_v               - retired instruction strobe
//   evt[NUM_EV]       - per-cycle event strobes
//   rd (slave)        - req/ack read port for counters and status
//   running/done      - state is RUN|DRAIN / DONE
//   timeout           - last window was closed by the watchdog
module perf_ctrl
    import perf_pkg::*;
#(
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned NUM_EV    = 4,
    parameter int unsigned TIMEOUT   = 100000,
    parameter int unsigned DRAIN_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              isHalt,
    input  logic              W_v,
    input  logic [NUM_EV-1:0] evt,
    perf_ctrl_if.slave        rd,
    output logic              running,
    output logic              done,
    output logic              timeout
);
    localparam int unsigned DRN_W = $clog2(DRAIN_CYC + 1);

    state_e           state_q, state_d;
    logic             timeout_q, timeout_d;
    logic [DRN_W-1:0] drn_q, drn_d;
    logic             clr_cnt;
    logic             in_run, in_drain;

    logic [CNT_W-1:0] cyc_cnt, ins_cnt;
    logic [CNT_W-1:0] ev_cnt [NUM_EV];
    logic [CNT_W-1:0] cyc_nxt;
    logic             to_hit;

    logic             rd_ack_q, rd_ack_d, rd_accept;
    logic [CNT_W-1:0] rd_data_q, rd_data_d, rd_mux;
    logic [4:0]       status5;

    assign in_run   = (state_q == ST_RUN);
    assign in_drain = (state_q == ST_DRAIN);

    // Watchdog compares the value the cycle counter will hold after this
    // edge, so a saturated counter that can never reach TIMEOUT never fires.
    assign cyc_nxt = (cyc_cnt == '1) ? cyc_cnt : cyc_cnt + 1'b1;
    assign to_hit  = (64'(cyc_nxt) == 64'(TIMEOUT));

    always_comb begin
        state_d   = state_q;
        timeout_d = timeout_q;
        drn_d     = drn_q;
        clr_cnt   = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    timeout_d = 1'b0;
                    drn_d     = '0;
                    clr_cnt   = 1'b1;
                end
            end
            ST_RUN: begin
                // halt/stop has priority over a same-cycle watchdog hit
                if (isHalt || stop) begin
                    state_d = ST_DRAIN;
                    drn_d   = '0;
                end else if (to_hit) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                drn_d = drn_q + 1'b1;
                if (drn_q == DRN_W'(DRAIN_CYC - 1)) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    sat_counter #(.CNT_W(CNT_W)) u_cyc (
        .clk(clk), .rst(rst), .clr(clr_cnt), .inc(in_run), .q(cyc_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_ins (
        .clk(clk), .rst(rst), .clr(clr_cnt), .inc(W_v && (in_run || in_drain)), .q(ins_cnt)
    );

    for (genvar g = 0; g < NUM_EV; g++) begin : g_ev
        sat_counter #(.CNT_W(CNT_W)) u_ev (
            .clk(clk), .rst(rst), .clr(clr_cnt), .inc(evt[g] && in_run), .q(ev_cnt[g])
        );
    end

    always_comb begin
        status5                          = '0;
        status5[STB_STATE +: 2]          = state_q;
        status5[STB_RUNNING]             = running;
        status5[STB_DONE]                = done;
        status5[STB_TIMEOUT]             = timeout_q;
    end

    always_comb begin
        rd_mux = '0;
        if (rd.rd_sel == SEL_CYCLE) begin
            rd_mux = cyc_cnt;
        end else if (rd.rd_sel == SEL_INSTR) begin
            rd_mux = ins_cnt;
        end else if (rd.rd_sel == SEL_STATUS) begin
            rd_mux = CNT_W'(status5);
        end else begin
            for (int unsigned i = 0; i < NUM_EV; i++) begin
                if (rd.rd_sel == 3'(SEL_EV0 + i)) begin
                    rd_mux = ev_cnt[i];
                end
            end
        end
    end

    // Blocking acceptance while ack is high forces a one-cycle gap between
    // back-to-back reads of a held request.
    assign rd_accept = rd.rd_req && !rd_ack_q;
    assign rd_ack_d  = rd_accept;
    assign rd_data_d = rd_accept ? rd_mux : rd_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            timeout_q <= 1'b0;
            drn_q     <= '0;
            rd_ack_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            timeout_q <= timeout_d;
            drn_q     <= drn_d;
            rd_ack_q  <= rd_ack_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign running    = in_run || in_drain;
    assign done       = (state_q == ST_DONE);
    assign timeout    = timeout_q;
    assign rd.rd_ack  = rd_ack_q;
    assign rd.rd_data = rd_data_q;
endmodule

// File: tb/tb_perf_ctrl.sv
// tb_perf_ctrl: two perf_ctrl instances driven by the same stimulus.
//   dut_a: CNT_W=32, TIMEOUT=50   (watchdog behaviour)
//   dut_b: CNT_W=4,  TIMEOUT=1e5  (saturation behaviour)
// A window-level reference model predicts state, flags and read data.
module tb_perf_ctrl;
    localparam int unsigned NEV   = 4;
    localparam int unsigned DRAIN = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0, stop = 1'b0, isHalt = 1'b0, W_v = 1'b0;
    logic [NEV-1:0] evt = '0;
    logic           rd_req = 1'b0;
    logic [2:0]     rd_sel = 3'd0;
    logic           run_a, done_a, to_a, run_b, done_b, to_b;

    int  checks = 0;
    int  failures = 0;
    bit  rd_auto = 1'b0;
    bit  final_chk = 1'b0;

    always #5 clk = ~clk;

    perf_ctrl_if #(.CNT_W(32)) if_a ();
    perf_ctrl_if #(.CNT_W(4))  if_b ();

    assign if_a.rd_req = rd_req;
    assign if_a.rd_sel = rd_sel;
    assign if_b.rd_req = rd_req;
    assign if_b.rd_sel = rd_sel;

    perf_ctrl #(.CNT_W(32), .NUM_EV(NEV), .TIMEOUT(50), .DRAIN_CYC(DRAIN)) dut_a (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .isHalt(isHalt), .W_v(W_v),
        .evt(evt), .rd(if_a.slave), .running(run_a), .done(done_a), .timeout(to_a)
    );

    perf_ctrl #(.CNT_W(4), .NUM_EV(NEV), .TIMEOUT(100000), .DRAIN_CYC(DRAIN)) dut_b (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .isHalt(isHalt), .W_v(W_v),
        .evt(evt), .rd(if_b.slave), .running(run_b), .done(done_b), .timeout(to_b)
    );

    // ---------------- reference model ----------------
    // st: 0 idle, 1 run, 2 drain, 3 done
    int              m_st  [2] = '{0, 0};
    longint unsigned m_cyc [2] = '{0, 0};
    longint unsigned m_ins [2] = '{0, 0};
    longint unsigned m_ev  [2][NEV];
    bit              m_to  [2] = '{0, 0};
    bit              m_ack [2] = '{0, 0};
    int              m_drn [2] = '{0, 0};
    longint unsigned exp_q0[$];
    longint unsigned exp_q1[$];

    function automatic longint unsigned maxv(input int k);
        return (k == 0) ? 64'hFFFF_FFFF : 64'd15;
    endfunction

    function automatic longint unsigned tov(input int k);
        return (k == 0) ? 64'd50 : 64'd100000;
    endfunction

    function automatic longint unsigned sat1(input int k, input longint unsigned v);
        return (v < maxv(k)) ? v + 1 : v;
    endfunction

    function automatic longint unsigned status_of(input int k);
        longint unsigned s;
        s = longint'(m_st[k]);
        if (m_st[k] == 1 || m_st[k] == 2) s += 4;
        if (m_st[k] == 3) s += 8;
        if (m_to[k]) s += 16;
        return s & maxv(k);
    endfunction

    function automatic longint unsigned rd_val(input int k, input int sel);
        if (sel == 0) return m_cyc[k];
        if (sel == 1) return m_ins[k];
        if (sel == 7) return status_of(k);
        if (sel >= 2 && sel < 2 + int'(NEV)) return m_ev[k][sel-2];
        return 0;
    endfunction

    task automatic push(input int k, input longint unsigned v);
        if (k == 0) exp_q0.push_back(v);
        else        exp_q1.push_back(v);
    endtask

    function automatic int qsize(input int k);
        return (k == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic longint unsigned qpop(input int k);
        return (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
    endfunction

    task automatic model_step(input int k);
        bit acc;
        if (rst) begin
            m_st[k] = 0; m_cyc[k] = 0; m_ins[k] = 0; m_to[k] = 0; m_ack[k] = 0; m_drn[k] = 0;
            for (int i = 0; i < int'(NEV); i++) m_ev[k][i] = 0;
        end else begin
            acc = rd_req && !m_ack[k];
            if (acc) push(k, rd_val(k, int'(rd_sel)));
            m_ack[k] = acc;
            if (m_st[k] == 0 || m_st[k] == 3) begin
                if (start) begin
                    m_st[k] = 1; m_cyc[k] = 0; m_ins[k] = 0; m_to[k] = 0; m_drn[k] = 0;
                    for (int i = 0; i < int'(NEV); i++) m_ev[k][i] = 0;
                end
            end else if (m_st[k] == 1) begin
                m_cyc[k] = sat1(k, m_cyc[k]);
                if (W_v) m_ins[k] = sat1(k, m_ins[k]);
                for (int i = 0; i < int'(NEV); i++) if (evt[i]) m_ev[k][i] = sat1(k, m_ev[k][i]);
                if (isHalt || stop) begin
                    m_st[k] = 2; m_drn[k] = 0;
                end else if (m_cyc[k] == tov(k)) begin
                    m_st[k] = 3; m_to[k] = 1;
                end
            end else begin
                if (W_v) m_ins[k] = sat1(k, m_ins[k]);
                m_drn[k] = m_drn[k] + 1;
                if (m_drn[k] == int'(DRAIN)) m_st[k] = 3;
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) for (int i = 0; i < int'(NEV); i++) m_ev[k][i] = 0;
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) model_step(k);
    end

    // ---------------- monitor / scoreboard ----------------
    task automatic chk(input string nm, input int k, input longint unsigned act,
                       input longint unsigned exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s dut%0d actual=%0d expected=%0d t=%0t", nm, k, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic            r, d, t, a;
            longint unsigned dat;
            r   = (k == 0) ? run_a : run_b;
            d   = (k == 0) ? done_a : done_b;
            t   = (k == 0) ? to_a : to_b;
            a   = (k == 0) ? if_a.rd_ack : if_b.rd_ack;
            dat = (k == 0) ? 64'(if_a.rd_data) : 64'(if_b.rd_data);
            chk("running", k, 64'(r), (m_st[k] == 1 || m_st[k] == 2) ? 64'd1 : 64'd0);
            chk("done",    k, 64'(d), (m_st[k] == 3) ? 64'd1 : 64'd0);
            chk("timeout", k, 64'(t), 64'(m_to[k]));
            chk("rd_ack",  k, 64'(a), 64'(m_ack[k]));
            if (a) begin
                if (qsize(k) == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rd_data dut%0d ack with no expected read actual=%0d", k, dat);
                end else begin
                    chk("rd_data", k, dat, qpop(k));
                end
            end
            if (final_chk) chk("pending_reads", k, 64'(qsize(k)), 64'd0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        if (rd_auto) begin
            if (!rd_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    rd_req = 1'b1;
                    rd_sel = 3'($urandom_range(0, 7));
                end
            end else if (if_a.rd_ack) begin
                if ($urandom_range(0, 1) == 0) rd_req = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        @(negedge clk);
        repeat (3) tick();
        rst = 1'b0;
        rd_auto = 1'b1;
        repeat (6) tick();

        // basic window: W_v on 10 of 20 RUN cycles, halt on cycle 20,
        // W_v on 2 of 4 drain cycles; a start on cycle 8 must be ignored
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            W_v    = (c % 2 == 0);
            evt    = NEV'($urandom);
            start  = (c == 8);
            isHalt = (c == 20);
            tick();
        end
        start = 1'b0; isHalt = 1'b0;
        for (int d = 1; d <= 4; d++) begin
            W_v = (d <= 2);
            evt = NEV'($urandom);
            tick();
        end
        W_v = 1'b0; evt = '0;
        repeat (12) tick();

        // watchdog window: no halt for 60 cycles
        start = 1'b1; tick(); start = 1'b0;
        repeat (60) begin
            W_v = 1'($urandom); evt = NEV'($urandom); tick();
        end
        W_v = 1'b0; evt = '0;
        repeat (6) tick();

        // halt on exactly the 50th RUN cycle: halt beats the watchdog
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 1; c <= 50; c++) begin
            W_v = 1'($urandom); evt = NEV'($urandom);
            isHalt = (c == 50);
            tick();
        end
        isHalt = 1'b0; W_v = 1'b0; evt = '0;
        repeat (10) tick();

        // saturation: evt[0] held for 20 RUN cycles
        start = 1'b1; tick(); start = 1'b0;
        repeat (20) begin
            evt = 4'b0001; W_v = 1'($urandom); tick();
        end
        evt = '0; W_v = 1'b0;
        stop = 1'b1; tick(); stop = 1'b0;
        repeat (16) tick();

        // reset while in DRAIN with a read outstanding
        start = 1'b1; tick(); start = 1'b0;
        repeat (5) begin W_v = 1'($urandom); tick(); end
        isHalt = 1'b1; tick(); isHalt = 1'b0;
        W_v = 1'b1; tick(); W_v = 1'b0;
        rd_auto = 1'b0;
        rd_req = 1'b1; rd_sel = 3'd0;
        rst = 1'b1; tick(); rst = 1'b0;
        rd_auto = 1'b1;
        repeat (14) tick();

        // random windows with stop/halt at random points
        repeat (3) begin
            start = 1'b1; tick(); start = 1'b0;
            repeat (40) begin
                W_v    = 1'($urandom);
                evt    = NEV'($urandom);
                start  = ($urandom_range(0, 9) == 0);
                stop   = ($urandom_range(0, 24) == 0);
                isHalt = ($urandom_range(0, 24) == 0);
                tick();
            end
            start = 1'b0; stop = 1'b0; isHalt = 1'b0; W_v = 1'b0; evt = '0;
            repeat (8) tick();
        end

        rd_auto = 1'b0;
        rd_req  = 1'b0;
        repeat (4) tick();
        final_chk = 1'b1;
        @(negedge clk);
        final_chk = 1'b0;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
